// File: rtl/process_element_div_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | process_element_div_pkg                                                    |
// | Shared widths, iteration constants and FSM encoding for the PE divider.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package process_element_div_pkg;

    localparam int DIVIDEND_W = 22;
    localparam int DIVISOR_W  = 7;
    localparam int QUOT_W     = 15;
    localparam int PREM_W     = DIVIDEND_W + 1;
    localparam int ITER       = 22;
    localparam int CNT_W      = 5;

    localparam logic [QUOT_W-1:0] QMAX = 15'h7FFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/process_element_div_22s_7s_15ns_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | process_element_div_22s_7s_15ns_if                                         |
// | Operand and result valid/ready channels of the PE divider.                 |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface process_element_div_22s_7s_15ns_if;
    import process_element_div_pkg::*;

    logic                  in_vld;
    logic                  in_rdy;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  out_vld;
    logic                  out_rdy;
    logic [QUOT_W-1:0]     quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  ovf;
    logic                  dbz;

    modport master (
        output in_vld, dividend, divisor, out_rdy,
        input  in_rdy, out_vld, quotient, remainder, ovf, dbz
    );

    modport slave (
        input  in_vld, dividend, divisor, out_rdy,
        output in_rdy, out_vld, quotient, remainder, ovf, dbz
    );
endinterface
`default_nettype wire

// File: rtl/process_element_div_step.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | process_element_div_step                                                   |
// | One combinational restoring-division step on the unsigned magnitudes.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module process_element_div_step
    import process_element_div_pkg::*;
(
    input  logic [PREM_W-1:0]    i_prem,
    input  logic                 i_bit,
    input  logic [DIVISOR_W-1:0] i_dvs,
    output logic [PREM_W-1:0]    o_prem,
    output logic                 o_qbit
);
    logic [PREM_W-1:0] w_shift;
    logic [PREM_W-1:0] w_dvs_ext;
    logic              w_ge;

    assign w_shift   = {i_prem[PREM_W-2:0], i_bit};
    assign w_dvs_ext = {{(PREM_W-DIVISOR_W){1'b0}}, i_dvs};

    // A set MSB means the true shifted value exceeds any divisor; the wrapped
    // difference is still exact because the result is below the divisor.
    assign w_ge   = i_prem[PREM_W-1] | (w_shift >= w_dvs_ext);
    assign o_qbit = w_ge;
    assign o_prem = w_ge ? (w_shift - w_dvs_ext) : w_shift;
endmodule
`default_nettype wire

// File: rtl/process_element_div_22s_7s_15ns.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | process_element_div_22s_7s_15ns                                            |
// | Iterative signed 22/7 divider with saturating unsigned 15-bit quotient.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module process_element_div_22s_7s_15ns
    import process_element_div_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic ce,
    process_element_div_22s_7s_15ns_if.slave bus
);
    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [DIVIDEND_W-1:0] r_dvd_mag;
    logic [DIVISOR_W-1:0]  r_dvs_mag;
    logic [PREM_W-1:0]     r_prem;
    logic                  r_neg_dvd;
    logic                  r_neg_dvs;
    logic                  r_out_vld;
    logic [QUOT_W-1:0]     r_quo;
    logic [DIVISOR_W-1:0]  r_rem;
    logic                  r_ovf;
    logic                  r_dbz;

    logic [DIVIDEND_W-1:0] w_dvd_mag;
    logic [DIVISOR_W-1:0]  w_dvs_mag;
    logic [PREM_W-1:0]     w_prem_next;
    logic                  w_qbit;
    logic [DIVIDEND_W-1:0] w_q_mag;
    logic [DIVISOR_W-1:0]  w_r_mag;
    logic                  w_q_neg;
    logic [QUOT_W-1:0]     w_quo_fin;
    logic [DIVISOR_W-1:0]  w_rem_fin;
    logic                  w_ovf_fin;

    // Magnitudes of the most negative operands fit because the fields are unsigned.
    assign w_dvd_mag = bus.dividend[DIVIDEND_W-1] ? ((~bus.dividend) + DIVIDEND_W'(1)) : bus.dividend;
    assign w_dvs_mag = bus.divisor[DIVISOR_W-1]   ? ((~bus.divisor) + DIVISOR_W'(1))   : bus.divisor;

    process_element_div_step u_step (
        .i_prem (r_prem),
        .i_bit  (r_dvd_mag[DIVIDEND_W-1]),
        .i_dvs  (r_dvs_mag),
        .o_prem (w_prem_next),
        .o_qbit (w_qbit)
    );

    // Final result formed from the last step's outputs so it lands with the DONE transition.
    always_comb begin
        w_q_mag   = {r_dvd_mag[DIVIDEND_W-2:0], w_qbit};
        w_r_mag   = w_prem_next[DIVISOR_W-1:0];
        w_q_neg   = (r_neg_dvd ^ r_neg_dvs) && (w_q_mag != '0);
        w_quo_fin = w_q_mag[QUOT_W-1:0];
        w_ovf_fin = 1'b0;
        if (w_q_neg) begin
            w_quo_fin = '0;
            w_ovf_fin = 1'b1;
        end else if (|w_q_mag[DIVIDEND_W-1:QUOT_W]) begin
            w_quo_fin = QMAX;
            w_ovf_fin = 1'b1;
        end
        w_rem_fin = r_neg_dvd ? ((~w_r_mag) + DIVISOR_W'(1)) : w_r_mag;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_dvd_mag <= '0;
            r_dvs_mag <= '0;
            r_prem    <= '0;
            r_neg_dvd <= 1'b0;
            r_neg_dvs <= 1'b0;
            r_out_vld <= 1'b0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_ovf     <= 1'b0;
            r_dbz     <= 1'b0;
        end else if (ce) begin
            case (r_state)
                IDLE: begin
                    if (bus.in_vld) begin
                        r_dvd_mag <= w_dvd_mag;
                        r_dvs_mag <= w_dvs_mag;
                        r_neg_dvd <= bus.dividend[DIVIDEND_W-1];
                        r_neg_dvs <= bus.divisor[DIVISOR_W-1];
                        r_prem    <= '0;
                        r_cnt     <= CNT_W'(ITER - 1);
                        if (w_dvs_mag == '0) begin
                            r_state   <= DONE;
                            r_out_vld <= 1'b1;
                            r_quo     <= QMAX;
                            r_rem     <= '0;
                            r_ovf     <= 1'b0;
                            r_dbz     <= 1'b1;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_prem    <= w_prem_next;
                    r_dvd_mag <= {r_dvd_mag[DIVIDEND_W-2:0], w_qbit};
                    r_cnt     <= r_cnt - CNT_W'(1);
                    if (r_cnt == '0) begin
                        r_state   <= DONE;
                        r_out_vld <= 1'b1;
                        r_quo     <= w_quo_fin;
                        r_rem     <= w_rem_fin;
                        r_ovf     <= w_ovf_fin;
                        r_dbz     <= 1'b0;
                    end
                end
                DONE: begin
                    if (bus.out_rdy) begin
                        r_state   <= IDLE;
                        r_out_vld <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_out_vld <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_rdy    = (r_state == IDLE);
    assign bus.out_vld   = r_out_vld;
    assign bus.quotient  = r_quo;
    assign bus.remainder = r_rem;
    assign bus.ovf       = r_ovf;
    assign bus.dbz       = r_dbz;
endmodule
`default_nettype wire

// File: tb/tb_process_element_div_22s_7s_15ns.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_process_element_div_22s_7s_15ns                                         |
// | Directed bench for the PE signed divider.                                  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_process_element_div_22s_7s_15ns;
    logic clk;
    logic reset_n;
    logic ce;
    int   n_tests;
    int   n_fail;

    process_element_div_22s_7s_15ns_if bus();

    process_element_div_22s_7s_15ns dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ce      (ce),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "/in_rdy"},  32'(bus.in_rdy),    32'd1);
        check({tag, "/out_vld"}, 32'(bus.out_vld),   32'd0);
        check({tag, "/quot"},    32'(bus.quotient),  32'd0);
        check({tag, "/rem"},     32'(bus.remainder), 32'd0);
        check({tag, "/ovf"},     32'(bus.ovf),       32'd0);
        check({tag, "/dbz"},     32'(bus.dbz),       32'd0);
    endtask

    // Latency counts the accept edge as cycle 0; the result is checked at first out_vld.
    task automatic run_op(input string tag, input logic [21:0] a, input logic [6:0] b,
                          input logic [14:0] eq, input logic [6:0] er, input logic eovf,
                          input logic edbz, input int elat, input int stall_at,
                          input int stall_len, input int hold);
        int lat;
        check({tag, "/in_rdy"}, 32'(bus.in_rdy), 32'd1);
        bus.in_vld   = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk); #1;
        bus.in_vld   = 1'b0;
        bus.dividend = 22'h155555;
        bus.divisor  = 7'h2A;
        lat = 1;
        while (!bus.out_vld && lat < 100) begin
            if (lat == stall_at) begin
                ce = 1'b0;
                repeat (stall_len) begin
                    @(posedge clk); #1;
                    lat++;
                end
                ce = 1'b1;
            end
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "/lat"},  32'(lat),           32'(elat));
        check({tag, "/quot"}, 32'(bus.quotient),  32'(eq));
        check({tag, "/rem"},  32'(bus.remainder), 32'(er));
        check({tag, "/ovf"},  32'(bus.ovf),       32'(eovf));
        check({tag, "/dbz"},  32'(bus.dbz),       32'(edbz));
        for (int i = 0; i < hold; i++) begin
            bus.in_vld   = (i == 1);
            bus.dividend = 22'd77;
            bus.divisor  = 7'd5;
            @(posedge clk); #1;
        end
        bus.in_vld = 1'b0;
        if (hold > 0) begin
            check({tag, "/hold_vld"},  32'(bus.out_vld),   32'd1);
            check({tag, "/hold_rdy"},  32'(bus.in_rdy),    32'd0);
            check({tag, "/hold_quot"}, 32'(bus.quotient),  32'(eq));
            check({tag, "/hold_rem"},  32'(bus.remainder), 32'(er));
        end
        bus.out_rdy = 1'b1;
        @(posedge clk); #1;
        bus.out_rdy = 1'b0;
        check({tag, "/pop_vld"}, 32'(bus.out_vld), 32'd0);
        check({tag, "/pop_rdy"}, 32'(bus.in_rdy),  32'd1);
    endtask

    initial begin
        int seen_vld;
        n_tests      = 0;
        n_fail       = 0;
        reset_n      = 1'b0;
        ce           = 1'b1;
        bus.in_vld   = 1'b0;
        bus.out_rdy  = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;

        run_op("max_exact",   22'(-2097088), 7'(-64), 15'd32767, 7'd0,     1'b0, 1'b0, 23, -1, 0, 0);
        run_op("p1000_p7",    22'd1000,      7'd7,    15'd142,   7'd6,     1'b0, 1'b0, 23, -1, 0, 10);
        run_op("n1000_n7",    22'(-1000),    7'(-7),  15'd142,   7'h7A,    1'b0, 1'b0, 23, -1, 0, 0);
        run_op("n5_p7",       22'(-5),       7'd7,    15'd0,     7'h7B,    1'b0, 1'b0, 23, -1, 0, 0);
        run_op("sat_big",     22'd2097151,   7'd1,    15'h7FFF,  7'd0,     1'b1, 1'b0, 23, -1, 0, 0);
        run_op("sat_neg",     22'(-1000),    7'd7,    15'd0,     7'h7A,    1'b1, 1'b0, 23, -1, 0, 0);
        run_op("div_zero",    22'd1234,      7'd0,    15'h7FFF,  7'd0,     1'b0, 1'b1, 1,  -1, 0, 3);
        run_op("ce_stall",    22'd5000,      7'd3,    15'd1666,  7'd2,     1'b0, 1'b0, 28, 10, 5, 0);

        // Abort a division at step 10 with an asynchronous reset.
        bus.in_vld   = 1'b1;
        bus.dividend = 22'd5000;
        bus.divisor  = 7'd3;
        @(posedge clk); #1;
        bus.in_vld = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(posedge clk); #1;
        reset_n = 1'b1;
        seen_vld = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (bus.out_vld) seen_vld = 1;
        end
        check("after_reset/no_vld", 32'(seen_vld), 32'd0);

        run_op("p300_n3",     22'd300,       7'(-3),  15'd0,     7'd0,     1'b1, 1'b0, 23, -1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
